// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage constants, state encoding and helpers.
package pc_fetch_unit_pkg;

    localparam int unsigned        XLEN               = 32;
    localparam int unsigned        FETCH_PC_STEP      = 4;
    localparam logic [XLEN-1:0]    FETCH_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned        FETCH_STATE_W      = 3;

    typedef enum logic [FETCH_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_REDIR = 3'd4,
        ST_DRAIN = 3'd5
    } fetch_state_e;

    // Instruction addresses must be 32-bit word aligned.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle between the fetch unit and its PC register, instruction memory and decode stage.
interface pc_fetch_unit_if #(
    parameter int unsigned DATA_W = pc_fetch_unit_pkg::XLEN
);
    // PC register
    logic [DATA_W-1:0] iv_Pc;
    logic              o_PcEnb;
    logic [DATA_W-1:0] ov_PcNext;
    // Instruction memory
    logic              o_MemReq;
    logic [DATA_W-1:0] ov_MemAddr;
    logic              i_MemGnt;
    logic              i_MemValid;
    logic [DATA_W-1:0] iv_MemRdata;
    // Decode
    logic              o_InstValid;
    logic [DATA_W-1:0] ov_Inst;
    logic [DATA_W-1:0] ov_InstPc;
    logic              i_InstReady;
    // Control flow
    logic              i_Redirect;
    logic [DATA_W-1:0] iv_RedirectPc;
    logic              o_AddrMisalign;

    modport master (
        input  iv_Pc, i_MemGnt, i_MemValid, iv_MemRdata, i_InstReady, i_Redirect, iv_RedirectPc,
        output o_PcEnb, ov_PcNext, o_MemReq, ov_MemAddr, o_InstValid, ov_Inst, ov_InstPc,
               o_AddrMisalign
    );

    modport slave (
        output iv_Pc, i_MemGnt, i_MemValid, iv_MemRdata, i_InstReady, i_Redirect, iv_RedirectPc,
        input  o_PcEnb, ov_PcNext, o_MemReq, ov_MemAddr, o_InstValid, ov_Inst, ov_InstPc,
               o_AddrMisalign
    );

endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch sequencer: one outstanding memory read, valid/ready hand-off to decode,
// redirect handling with drop/drain of in-flight data.
module pc_fetch_unit #(
    parameter int unsigned       DATA_W       = pc_fetch_unit_pkg::XLEN,
    parameter logic [DATA_W-1:0] RESET_VECTOR = pc_fetch_unit_pkg::FETCH_RESET_VECTOR,
    parameter int unsigned       PC_STEP      = pc_fetch_unit_pkg::FETCH_PC_STEP
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    pc_fetch_unit_if.master bus
);
    import pc_fetch_unit_pkg::*;

    fetch_state_e      state, state_nxt;

    logic              pc_enb,     pc_enb_nxt;
    logic [DATA_W-1:0] pc_next,    pc_next_nxt;
    logic              inst_valid, inst_valid_nxt;
    logic [DATA_W-1:0] inst,       inst_nxt;
    logic [DATA_W-1:0] inst_pc,    inst_pc_nxt;
    logic              misalign,   misalign_nxt;
    logic [DATA_W-1:0] req_pc,     req_pc_nxt;

    logic pc_aligned;
    logic mem_req_c;
    logic granted;
    logic accepted;
    logic redirect;

    // Request is a Moore decode of the state register and the registered PC, so the
    // address tracks the PC register in the same cycle it enters REQ.
    assign pc_aligned = is_word_aligned(bus.iv_Pc[1:0]);
    assign mem_req_c  = (state == ST_REQ) && pc_aligned;
    assign granted    = mem_req_c && bus.i_MemGnt;
    assign accepted   = inst_valid && bus.i_InstReady;
    assign redirect   = bus.i_Redirect && (state != ST_IDLE);

    // State register.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; redirect dominates, and a request already granted must be drained.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) begin
                    state_nxt = granted ? ST_DRAIN : ST_REDIR;
                end else if (granted) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    state_nxt = bus.i_MemValid ? ST_REDIR : ST_DRAIN;
                end else if (bus.i_MemValid) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    state_nxt = ST_REDIR;
                end else if (accepted) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REDIR: begin
                // A back-to-back redirect restarts the one-cycle PC load.
                state_nxt = redirect ? ST_REDIR : ST_REQ;
            end
            ST_DRAIN: begin
                // Data returning with a new redirect still needs a cycle for the PC load.
                if (bus.i_MemValid) begin
                    state_nxt = redirect ? ST_REDIR : ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and the request-address latch.
    always_comb begin
        pc_enb_nxt     = 1'b0;
        pc_next_nxt    = pc_next;
        inst_valid_nxt = inst_valid;
        inst_nxt       = inst;
        inst_pc_nxt    = inst_pc;
        misalign_nxt   = misalign;
        req_pc_nxt     = req_pc;
        if (redirect) begin
            pc_enb_nxt     = 1'b1;
            pc_next_nxt    = bus.iv_RedirectPc;
            inst_valid_nxt = 1'b0;
            misalign_nxt   = 1'b0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (!pc_aligned) begin
                        misalign_nxt = 1'b1;
                    end else if (bus.i_MemGnt) begin
                        req_pc_nxt = bus.iv_Pc;
                    end
                end
                ST_WAIT: begin
                    if (bus.i_MemValid) begin
                        inst_nxt       = bus.iv_MemRdata;
                        inst_pc_nxt    = req_pc;
                        inst_valid_nxt = 1'b1;
                        pc_next_nxt    = DATA_W'(req_pc + DATA_W'(PC_STEP));
                        pc_enb_nxt     = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (accepted) begin
                        inst_valid_nxt = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output and request-address registers.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            pc_enb     <= 1'b0;
            pc_next    <= RESET_VECTOR;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= RESET_VECTOR;
            misalign   <= 1'b0;
            req_pc     <= RESET_VECTOR;
        end else begin
            pc_enb     <= pc_enb_nxt;
            pc_next    <= pc_next_nxt;
            inst_valid <= inst_valid_nxt;
            inst       <= inst_nxt;
            inst_pc    <= inst_pc_nxt;
            misalign   <= misalign_nxt;
            req_pc     <= req_pc_nxt;
        end
    end

    assign bus.o_PcEnb        = pc_enb;
    assign bus.ov_PcNext      = pc_next;
    assign bus.o_MemReq       = mem_req_c;
    assign bus.ov_MemAddr     = mem_req_c ? bus.iv_Pc : '0;
    assign bus.o_InstValid    = inst_valid;
    assign bus.ov_Inst        = inst;
    assign bus.ov_InstPc      = inst_pc;
    assign bus.o_AddrMisalign = misalign;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a behavioural PC register.
module tb_pc_fetch_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pc_fetch_unit_if #(.DATA_W(32)) bus ();

    pc_fetch_unit #(
        .DATA_W      (32),
        .RESET_VECTOR(32'h0000_0000),
        .PC_STEP     (4)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural PC register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.iv_Pc <= 32'h0;
        end else if (bus.o_PcEnb) begin
            bus.iv_Pc <= bus.ov_PcNext;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] pc;
        int          stall;
    } vec_t;

    vec_t vecs [3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Grant in REQ then return data in WAIT; leaves the DUT in its first HOLD cycle.
    task automatic issue_fetch(input logic [31:0] rdata);
        bus.i_MemGnt = 1'b1;
        step();
        bus.i_MemGnt = 1'b0;
        chk("wait_no_req", 32'(bus.o_MemReq), 32'd0);
        bus.i_MemValid  = 1'b1;
        bus.iv_MemRdata = rdata;
        step();
        bus.i_MemValid  = 1'b0;
        bus.iv_MemRdata = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int enb_cnt;
        checks = 0;
        errors = 0;

        vecs[0] = '{rdata: 32'h0000_0013, pc: 32'h0, stall: 0};
        vecs[1] = '{rdata: 32'h0010_0093, pc: 32'h4, stall: 5};
        vecs[2] = '{rdata: 32'h0020_0113, pc: 32'h8, stall: 0};

        rst_n             = 1'b0;
        bus.i_MemGnt      = 1'b0;
        bus.i_MemValid    = 1'b0;
        bus.iv_MemRdata   = 32'h0;
        bus.i_InstReady   = 1'b0;
        bus.i_Redirect    = 1'b0;
        bus.iv_RedirectPc = 32'h0;

        // Reset state
        step(); step(); step();
        chk("rst_pc_enb",   32'(bus.o_PcEnb),        32'd0);
        chk("rst_mem_req",  32'(bus.o_MemReq),       32'd0);
        chk("rst_valid",    32'(bus.o_InstValid),    32'd0);
        chk("rst_misalign", 32'(bus.o_AddrMisalign), 32'd0);
        chk("rst_pc_next",  bus.ov_PcNext,           32'h0);
        chk("rst_inst_pc",  bus.ov_InstPc,           32'h0);
        chk("rst_inst",     bus.ov_Inst,             32'h0);
        chk("rst_mem_addr", bus.ov_MemAddr,          32'h0);
        rst_n = 1'b1;
        step(); step();
        chk("post_rst_req",  32'(bus.o_MemReq), 32'd1);
        chk("post_rst_addr", bus.ov_MemAddr,    32'h0);

        // Sequential fetch with backpressure on the middle instruction
        for (int i = 0; i < 3; i++) begin
            chk("seq_req",  32'(bus.o_MemReq), 32'd1);
            chk("seq_addr", bus.ov_MemAddr,    vecs[i].pc);
            issue_fetch(vecs[i].rdata);
            chk("seq_valid",   32'(bus.o_InstValid), 32'd1);
            chk("seq_inst",    bus.ov_Inst,          vecs[i].rdata);
            chk("seq_inst_pc", bus.ov_InstPc,        vecs[i].pc);
            chk("seq_pc_next", bus.ov_PcNext,        vecs[i].pc + 32'd4);
            enb_cnt = int'(bus.o_PcEnb);
            for (int k = 0; k < vecs[i].stall; k++) begin
                step();
                enb_cnt += int'(bus.o_PcEnb);
                chk("bp_inst",    bus.ov_Inst,          vecs[i].rdata);
                chk("bp_inst_pc", bus.ov_InstPc,        vecs[i].pc);
                chk("bp_valid",   32'(bus.o_InstValid), 32'd1);
                chk("bp_no_req",  32'(bus.o_MemReq),    32'd0);
            end
            bus.i_InstReady = 1'b1;
            step();
            bus.i_InstReady = 1'b0;
            enb_cnt += int'(bus.o_PcEnb);
            chk("seq_enb_pulses", 32'(enb_cnt),          32'd1);
            chk("seq_released",   32'(bus.o_InstValid), 32'd0);
        end

        // Redirect during WAIT, data arrives later and is drained
        chk("r1_addr", bus.ov_MemAddr, 32'hC);
        bus.i_MemGnt = 1'b1;
        step();
        bus.i_MemGnt      = 1'b0;
        bus.i_Redirect    = 1'b1;
        bus.iv_RedirectPc = 32'h100;
        step();
        bus.i_Redirect = 1'b0;
        chk("r1_pc_enb",  32'(bus.o_PcEnb),     32'd1);
        chk("r1_pc_next", bus.ov_PcNext,        32'h100);
        chk("r1_no_req",  32'(bus.o_MemReq),    32'd0);
        step();
        chk("r1_drain_no_req", 32'(bus.o_MemReq), 32'd0);
        bus.i_MemValid  = 1'b1;
        bus.iv_MemRdata = 32'hDEAD_BEEF;
        step();
        bus.i_MemValid  = 1'b0;
        bus.iv_MemRdata = 32'h0;
        chk("r1_valid", 32'(bus.o_InstValid), 32'd0);
        chk("r1_inst",  bus.ov_Inst,          32'h0020_0113);
        chk("r1_req",   32'(bus.o_MemReq),    32'd1);
        chk("r1_addr2", bus.ov_MemAddr,       32'h100);

        // Redirect coincident with read data in WAIT
        bus.i_MemGnt = 1'b1;
        step();
        bus.i_MemGnt      = 1'b0;
        bus.i_MemValid    = 1'b1;
        bus.iv_MemRdata   = 32'hDEAD_BEEF;
        bus.i_Redirect    = 1'b1;
        bus.iv_RedirectPc = 32'h200;
        step();
        bus.i_MemValid = 1'b0;
        bus.i_Redirect = 1'b0;
        chk("r2_valid",   32'(bus.o_InstValid), 32'd0);
        chk("r2_inst",    bus.ov_Inst,          32'h0020_0113);
        chk("r2_pc_enb",  32'(bus.o_PcEnb),     32'd1);
        chk("r2_pc_next", bus.ov_PcNext,        32'h200);
        step();
        chk("r2_req",  32'(bus.o_MemReq), 32'd1);
        chk("r2_addr", bus.ov_MemAddr,    32'h200);

        // Misaligned redirect target, then recovery
        bus.i_Redirect    = 1'b1;
        bus.iv_RedirectPc = 32'h102;
        step();
        bus.i_Redirect = 1'b0;
        step();
        chk("mis_no_req_0", 32'(bus.o_MemReq), 32'd0);
        step();
        chk("mis_flag",     32'(bus.o_AddrMisalign), 32'd1);
        chk("mis_no_req_1", 32'(bus.o_MemReq),       32'd0);
        bus.i_MemGnt = 1'b1;
        step();
        bus.i_MemGnt = 1'b0;
        chk("mis_sticky",   32'(bus.o_AddrMisalign), 32'd1);
        chk("mis_no_req_2", 32'(bus.o_MemReq),       32'd0);
        bus.i_Redirect    = 1'b1;
        bus.iv_RedirectPc = 32'h104;
        step();
        bus.i_Redirect = 1'b0;
        chk("mis_cleared", 32'(bus.o_AddrMisalign), 32'd0);
        step();
        chk("mis_req",  32'(bus.o_MemReq), 32'd1);
        chk("mis_addr", bus.ov_MemAddr,    32'h104);
        issue_fetch(32'h0040_0213);
        chk("mis_fetch_inst_pc", bus.ov_InstPc, 32'h104);
        chk("mis_fetch_inst",    bus.ov_Inst,   32'h0040_0213);
        bus.i_InstReady = 1'b1;
        step();
        bus.i_InstReady = 1'b0;

        // Reset while a read is outstanding; the late data must be ignored
        chk("rw_addr", bus.ov_MemAddr, 32'h108);
        bus.i_MemGnt = 1'b1;
        step();
        bus.i_MemGnt = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rw_valid_0", 32'(bus.o_InstValid), 32'd0);
        chk("rw_no_req",  32'(bus.o_MemReq),    32'd0);
        bus.i_MemValid  = 1'b1;
        bus.iv_MemRdata = 32'hCAFE_BABE;
        step();
        bus.i_MemValid  = 1'b0;
        bus.iv_MemRdata = 32'h0;
        chk("rw_valid_1", 32'(bus.o_InstValid), 32'd0);
        chk("rw_req",     32'(bus.o_MemReq),    32'd1);
        chk("rw_addr2",   bus.ov_MemAddr,       32'h0);
        step();
        chk("rw_valid_2", 32'(bus.o_InstValid), 32'd0);

        // PC wrap at the top of the address space
        bus.i_Redirect    = 1'b1;
        bus.iv_RedirectPc = 32'hFFFF_FFFC;
        step();
        bus.i_Redirect = 1'b0;
        step();
        chk("wrap_addr", bus.ov_MemAddr, 32'hFFFF_FFFC);
        issue_fetch(32'h0050_0293);
        chk("wrap_inst_pc", bus.ov_InstPc, 32'hFFFF_FFFC);
        chk("wrap_pc_next", bus.ov_PcNext, 32'h0);

        // Redirect in HOLD drops the instruction even with ready asserted
        bus.i_InstReady   = 1'b1;
        bus.i_Redirect    = 1'b1;
        bus.iv_RedirectPc = 32'h40;
        step();
        bus.i_InstReady = 1'b0;
        bus.i_Redirect  = 1'b0;
        chk("hr_valid",   32'(bus.o_InstValid), 32'd0);
        chk("hr_pc_enb",  32'(bus.o_PcEnb),     32'd1);
        chk("hr_pc_next", bus.ov_PcNext,        32'h40);
        step();
        chk("hr_req",  32'(bus.o_MemReq), 32'd1);
        chk("hr_addr", bus.ov_MemAddr,    32'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
